// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one 4-bit ALU between two requesters. Operations are accepted with
//   per-port valid/ready handshakes and round-robin arbitration. The operands
//   are held on the ALU for EXEC_CYCLES cycles before the result is captured.
//   The result is returned on one tagged response channel.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req{0,1}_valid/ready      request handshake per port
//   req{0,1}_a/_b/_sel        operands and ALU select per port
//   alu_a, alu_b, alu_sel     registered drive into the shared ALU
//   alu_out, alu_carry        ALU result path
//   rsp_valid/ready           response handshake
//   rsp_id/result/carry       issuing port, captured result, captured carry
//   busy                      FSM is not IDLE
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_out,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic       rsp_carry,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    logic       last_grant;
    logic       op_id;
    logic [3:0] exec_cnt;

    // On a tie the port that did not win last time gets the grant.
    assign req0_ready = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
    assign req1_ready = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_id      <= 1'b0;
            exec_cnt   <= 4'd0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_sel    <= 3'd0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 4'd0;
            rsp_carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        alu_a      <= req1_ready ? req1_a   : req0_a;
                        alu_b      <= req1_ready ? req1_b   : req0_b;
                        alu_sel    <= req1_ready ? req1_sel : req0_sel;
                        op_id      <= req1_ready;
                        last_grant <= req1_ready;
                        exec_cnt   <= 4'(EXEC_CYCLES - 1);
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_cnt == 4'd0) begin
                        rsp_result <= alu_out;
                        rsp_carry  <= alu_carry;
                        rsp_id     <= op_id;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Return to IDLE only; a new accept needs a full IDLE cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: one instance with EXEC_CYCLES=1 driven through a
// response scoreboard, plus one instance with EXEC_CYCLES=4 for the
// multi-cycle execute case. Each instance has a behavioural ALU attached.
module tb_alu_arbiter;

    logic clk, rst;

    // EXEC_CYCLES = 1 instance
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_sel, req1_sel;
    logic [3:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_sel;
    logic       alu_carry;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, busy;
    logic [3:0] rsp_result;

    // EXEC_CYCLES = 4 instance
    logic       m_req0_valid, m_req0_ready, m_req1_valid, m_req1_ready;
    logic [3:0] m_req0_a, m_req0_b, m_req1_a, m_req1_b;
    logic [2:0] m_req0_sel, m_req1_sel;
    logic [3:0] m_alu_a, m_alu_b, m_alu_out;
    logic [2:0] m_alu_sel;
    logic       m_alu_carry;
    logic       m_rsp_valid, m_rsp_ready, m_rsp_id, m_rsp_carry, m_busy;
    logic [3:0] m_rsp_result;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected responses {id, carry, result} in issue order.
    logic [5:0] sb[$];

    alu_arbiter #(.EXEC_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .busy(busy)
    );

    alu_arbiter #(.EXEC_CYCLES(4)) dut_m (
        .clk(clk), .rst(rst),
        .req0_valid(m_req0_valid), .req0_ready(m_req0_ready),
        .req0_a(m_req0_a), .req0_b(m_req0_b), .req0_sel(m_req0_sel),
        .req1_valid(m_req1_valid), .req1_ready(m_req1_ready),
        .req1_a(m_req1_a), .req1_b(m_req1_b), .req1_sel(m_req1_sel),
        .alu_a(m_alu_a), .alu_b(m_alu_b), .alu_sel(m_alu_sel),
        .alu_out(m_alu_out), .alu_carry(m_alu_carry),
        .rsp_valid(m_rsp_valid), .rsp_ready(m_rsp_ready), .rsp_id(m_rsp_id),
        .rsp_result(m_rsp_result), .rsp_carry(m_rsp_carry), .busy(m_busy)
    );

    // Behavioural ALU: {carry, result}; carry is always the A+B carry.
    function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] s);
        logic [4:0] sum;
        logic [7:0] prod;
        logic [3:0] r;
        sum  = {1'b0, a} + {1'b0, b};
        prod = {4'd0, a} * {4'd0, b};
        case (s)
            3'd0:    r = sum[3:0];
            3'd1:    r = a - b;
            3'd2:    r = prod[3:0];
            3'd3:    r = (b == 4'd0) ? 4'd0 : a / b;
            3'd4:    r = a & b;
            3'd5:    r = a | b;
            3'd6:    r = ~(a & b);
            default: r = ~(a | b);
        endcase
        return {sum[4], r};
    endfunction

    always_comb {alu_carry, alu_out}     = alu_model(alu_a, alu_b, alu_sel);
    always_comb {m_alu_carry, m_alu_out} = alu_model(m_alu_a, m_alu_b, m_alu_sel);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Response monitor: inputs settle 2 time units after posedge, so the
    // negedge sees exactly what the next posedge will act on.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", {rsp_id, rsp_carry, rsp_result}, 32'hffff_ffff);
            end else begin
                check("rsp", {rsp_id, rsp_carry, rsp_result}, sb.pop_front());
            end
        end
    end

    // Waits (bounded) for a combinational grant; returns {req1_ready, req0_ready}.
    task automatic wait_grant(output logic [1:0] g);
        int n;
        n = 0;
        #1;
        while (!(req0_ready || req1_ready) && n < 50) begin
            @(posedge clk); #3;
            n++;
        end
        g = {req1_ready, req0_ready};
    endtask

    task automatic do_op(input bit port, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] s, input logic [5:0] exp);
        logic [1:0] g;
        if (!port) begin
            req0_a = a; req0_b = b; req0_sel = s; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_sel = s; req1_valid = 1'b1;
        end
        sb.push_back(exp);
        wait_grant(g);
        check("grant", g, port ? 2'b10 : 2'b01);
        @(posedge clk); #2;
        if (!port) req0_valid = 1'b0;
        else       req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        logic [1:0] g;
        int n, held;

        rst = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
        rsp_ready = 1'b1;
        m_req0_valid = 0; m_req0_a = 0; m_req0_b = 0; m_req0_sel = 0;
        m_req1_valid = 0; m_req1_a = 0; m_req1_b = 0; m_req1_sel = 0;
        m_rsp_ready = 1'b1;

        #3;
        check("reset_outputs", {alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_result,
                                rsp_carry, busy, req0_ready, req1_ready}, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;

        // Single op: 7+9 wraps to 0 with carry; response after the accept edge + 1.
        do_op(1'b0, 4'd7, 4'd9, 3'd0, {1'b0, 1'b1, 4'd0});
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        check("single_latency", n, 2);
        drain();

        // Port 1: divide-by-zero, NAND, NOR.
        do_op(1'b1, 4'd12, 4'd0,  3'd3, {1'b1, 1'b0, 4'd0});
        do_op(1'b1, 4'd12, 4'd10, 3'd6, {1'b1, 1'b1, 4'd7});
        do_op(1'b1, 4'd12, 4'd10, 3'd7, {1'b1, 1'b1, 4'd1});
        drain();

        // Tie fairness: both valid the whole time, grants alternate from port 0.
        req0_a = 4'd6; req0_b = 4'd3; req0_sel = 3'd3; req0_valid = 1'b1;
        req1_a = 4'd5; req1_b = 4'd5; req1_sel = 3'd2; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back((i % 2 == 0) ? {1'b0, 1'b0, 4'd2} : {1'b1, 1'b0, 4'd9});
        end
        for (int i = 0; i < 4; i++) begin
            wait_grant(g);
            check("tie_grant", g, (i % 2 == 0) ? 2'b01 : 2'b10);
            @(posedge clk); #2;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Back-pressure: response held while port 0 waits.
        rsp_ready = 1'b0;
        do_op(1'b0, 4'd1, 4'd2, 3'd0, {1'b0, 1'b0, 4'd3});
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        req0_a = 4'd2; req0_b = 4'd2; req0_sel = 3'd4; req0_valid = 1'b1;
        sb.push_back({1'b0, 1'b0, 4'd2});
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_rsp_hold", {rsp_valid, rsp_id, rsp_carry, rsp_result}, {1'b1, 1'b0, 1'b0, 4'd3});
            check("bp_ready0", req0_ready, 1'b0);
            check("bp_busy", busy, 1'b1);
            @(posedge clk); #2;
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_no_accept_in_handshake", req0_ready, 1'b0);
        @(posedge clk); #3;
        check("bp_accept_first_idle", req0_ready, 1'b1);
        @(posedge clk); #2;
        req0_valid = 1'b0;
        drain();

        // Reset mid-EXEC: everything drops at once, op discarded.
        req0_a = 4'd5; req0_b = 4'd5; req0_sel = 3'd0; req0_valid = 1'b1;
        wait_grant(g);
        @(posedge clk); #2;
        req0_valid = 1'b0;
        check("pre_reset_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("reset_mid_exec", {busy, rsp_valid, alu_a, alu_b, alu_sel}, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        req0_a = 4'd1;  req0_b = 4'd1; req0_sel = 3'd0; req0_valid = 1'b1;
        req1_a = 4'd15; req1_b = 4'd1; req1_sel = 3'd0; req1_valid = 1'b1;
        sb.push_back({1'b0, 1'b0, 4'd2});
        sb.push_back({1'b1, 1'b1, 4'd0});
        wait_grant(g);
        check("post_reset_tie", g, 2'b01);
        @(posedge clk); #2;
        req0_valid = 1'b0;
        wait_grant(g);
        check("post_reset_second", g, 2'b10);
        @(posedge clk); #2;
        req1_valid = 1'b0;
        drain();

        // Multi-cycle execute on the EXEC_CYCLES=4 instance: 3|4 = 7.
        m_req0_a = 4'd3; m_req0_b = 4'd4; m_req0_sel = 3'd5; m_req0_valid = 1'b1;
        #1;
        check("mc_ready", m_req0_ready, 1'b1);
        @(posedge clk); #2;
        m_req0_valid = 1'b0;
        n = 1;
        held = 0;
        while (!m_rsp_valid && n < 40) begin
            if (m_alu_a == 4'd3 && m_alu_b == 4'd4 && m_alu_sel == 3'd5 && m_busy) held++;
            @(posedge clk); #2;
            n++;
        end
        check("mc_hold", held, 4);
        check("mc_latency", n, 5);
        check("mc_rsp", {m_rsp_id, m_rsp_carry, m_rsp_result}, {1'b0, 1'b0, 4'd7});
        @(posedge clk); #2;
        check("mc_idle", m_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
